// File: rtl/alu_seq_if.sv
// Request/response bundle between the datapath controller (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       outFlags;
  logic             flags_wr;
  logic [4:0]       flags_in;

  modport master (
    output in_valid, op, input1, input2, out_ready, flags_wr, flags_in,
    input  in_ready, out_valid, result, outFlags
  );

  modport slave (
    input  in_valid, op, input1, input2, out_ready, flags_wr, flags_in,
    output in_ready, out_valid, result, outFlags
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops 1-15, iterative shift-by-N and shift-add multiply,
// with an internal flag register {N,Z,F,G,C}.
module alu_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned FC = 0, FG = 1, FF = 2, FZ = 3, FN = 4;

  localparam logic [4:0] OP_ADD = 5'd1,  OP_ADDU = 5'd2,  OP_ADDC = 5'd3,  OP_ADDCU = 5'd4;
  localparam logic [4:0] OP_SUB = 5'd5,  OP_CMP  = 5'd6,  OP_CMPU = 5'd7,  OP_AND   = 5'd8;
  localparam logic [4:0] OP_OR  = 5'd9,  OP_XOR  = 5'd10, OP_NOT  = 5'd11, OP_LSH   = 5'd12;
  localparam logic [4:0] OP_RSH = 5'd13, OP_ALSH = 5'd14, OP_ARSH = 5'd15, OP_LSHN  = 5'd16;
  localparam logic [4:0] OP_RSHN = 5'd17, OP_ARSHN = 5'd18, OP_MUL = 5'd19;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             r_state;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic [4:0]         r_flags;
  logic               r_in_ready;
  logic               r_out_valid;

  logic               w_accept;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH:0]     w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res1;
  logic [4:0]         w_flags1;
  logic               w_zn1;
  logic               w_multi;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_res_x;
  logic [4:0]         w_flags_x;
  logic               w_last;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_a      = bus.input1;
  assign w_b      = bus.input2;
  assign w_shamt  = bus.input2[SHAMT_W-1:0];
  assign w_cin    = {{WIDTH{1'b0}}, r_flags[FC]};

  // Result and flags of an op completed at the accept edge
  always_comb begin
    w_sum    = '0;
    w_res1   = '0;
    w_flags1 = r_flags;
    w_zn1    = 1'b0;
    w_multi  = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADDC: begin
        w_sum        = {1'b0, w_a} + {1'b0, w_b} + ((bus.op == OP_ADDC) ? w_cin : '0);
        w_res1       = w_sum[WIDTH-1:0];
        w_flags1[FC] = w_sum[WIDTH];
        w_flags1[FF] = (w_a[MSB] == w_b[MSB]) && (w_res1[MSB] != w_a[MSB]);
        w_zn1        = 1'b1;
      end
      OP_ADDU, OP_ADDCU: begin
        w_sum        = {1'b0, w_a} + {1'b0, w_b} + ((bus.op == OP_ADDCU) ? w_cin : '0);
        w_res1       = w_sum[WIDTH-1:0];
        w_flags1[FC] = w_sum[WIDTH];
        w_flags1[FZ] = (w_res1 == '0);
      end
      OP_SUB: begin
        w_sum        = {1'b0, w_a} - {1'b0, w_b};
        w_res1       = w_sum[WIDTH-1:0];
        w_flags1[FC] = w_sum[WIDTH];
        w_flags1[FF] = (w_a[MSB] != w_b[MSB]) && (w_res1[MSB] != w_a[MSB]);
        w_zn1        = 1'b1;
      end
      OP_CMP: begin
        w_res1       = w_a;
        w_flags1[FG] = $signed(w_a) > $signed(w_b);
        w_flags1[FZ] = (w_a == w_b);
        w_flags1[FN] = $signed(w_a) < $signed(w_b);
      end
      OP_CMPU: begin
        w_res1       = w_a;
        w_flags1[FG] = (w_a > w_b);
        w_flags1[FZ] = (w_a == w_b);
        w_flags1[FN] = (w_a < w_b);
      end
      OP_AND:          begin w_res1 = w_a & w_b;              w_zn1 = 1'b1; end
      OP_OR:           begin w_res1 = w_a | w_b;              w_zn1 = 1'b1; end
      OP_XOR:          begin w_res1 = w_a ^ w_b;              w_zn1 = 1'b1; end
      OP_NOT:          begin w_res1 = ~w_a;                   w_zn1 = 1'b1; end
      OP_LSH, OP_ALSH: begin w_res1 = w_a << 1;               w_zn1 = 1'b1; end
      OP_RSH:          begin w_res1 = w_a >> 1;               w_zn1 = 1'b1; end
      OP_ARSH:         begin w_res1 = {w_a[MSB], w_a[MSB:1]}; w_zn1 = 1'b1; end
      OP_LSHN, OP_RSHN, OP_ARSHN: begin
        // A zero shift amount has no work and completes like a single-cycle op
        w_res1  = w_a;
        w_zn1   = 1'b1;
        w_multi = (w_shamt != '0);
      end
      OP_MUL:  w_multi = 1'b1;
      default: w_res1 = '0;
    endcase
    if (w_zn1) begin
      w_flags1[FZ] = (w_res1 == '0);
      w_flags1[FN] = w_res1[MSB];
    end
  end

  // One iteration of a multi-cycle op and its completion values
  always_comb begin
    case (r_op)
      OP_LSHN:  w_shift_nxt = r_a << 1;
      OP_RSHN:  w_shift_nxt = r_a >> 1;
      OP_ARSHN: w_shift_nxt = {r_a[MSB], r_a[MSB:1]};
      default:  w_shift_nxt = r_a;
    endcase
    w_acc_nxt = r_acc + (r_b[0] ? r_mcand : '0);
    w_last    = (r_cnt == CNT_W'(1));
    w_flags_x = r_flags;
    if (r_op == OP_MUL) begin
      w_res_x       = w_acc_nxt[WIDTH-1:0];
      w_flags_x[FC] = |w_acc_nxt[2*WIDTH-1:WIDTH];
    end else begin
      w_res_x = w_shift_nxt;
    end
    w_flags_x[FZ] = (w_res_x == '0);
    w_flags_x[FN] = w_res_x[MSB];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= bus.op;
            r_a        <= w_a;
            r_b        <= w_b;
            r_mcand    <= {{WIDTH{1'b0}}, w_a};
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            if (w_multi) begin
              r_state <= S_EXEC;
              r_cnt   <= (bus.op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(w_shamt);
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res1;
              r_flags     <= w_flags1;
            end
          end
        end
        S_EXEC: begin
          r_a     <= w_shift_nxt;
          r_b     <= r_b >> 1;
          r_mcand <= r_mcand << 1;
          r_acc   <= w_acc_nxt;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_res_x;
            r_flags     <= w_flags_x;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
      // Context restore overrides any op flag update in the same cycle
      if (bus.flags_wr) r_flags <= bus.flags_in;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.outFlags  = r_flags;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 16-bit instance for all op classes and handshake corners,
// plus a 32-bit instance for the wide signed-overflow case.
module tb_alu_seq;
  localparam logic [4:0] ADD = 5'd1, ADDU = 5'd2, ADDC = 5'd3, SUB = 5'd5, CMP = 5'd6;
  localparam logic [4:0] CMPU = 5'd7, AND_ = 5'd8, XOR_ = 5'd10, NOT_ = 5'd11, LSH = 5'd12;
  localparam logic [4:0] RSH = 5'd13, ARSH = 5'd15, LSHN = 5'd16, ARSHN = 5'd18, MUL = 5'd19;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) bus16 ();
  alu_seq_if #(.WIDTH(32)) bus32 ();

  alu_seq #(.WIDTH(16)) u_dut (.clk(clk), .reset(reset), .bus(bus16.slave));
  alu_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.op       = op;
    bus16.input1   = a;
    bus16.input2   = b;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!bus16.out_valid) chk("timeout", 64'(bus16.out_valid), 64'd1);
  endtask

  task automatic take();
    @(negedge clk);
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1 bus16.out_ready = 1'b0;
    chk("release_ready", 64'(bus16.in_ready), 64'd1);
  endtask

  task automatic wr_flags(input logic [4:0] v);
    @(negedge clk);
    bus16.flags_wr = 1'b1;
    bus16.flags_in = v;
    @(posedge clk);
    #1 bus16.flags_wr = 1'b0;
    chk("flags_wr", 64'(bus16.outFlags), 64'(v));
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic [4:0] exp_flags, input int exp_lat);
    int lat;
    issue(op, a, b, lat);
    chk({tag, "_res"}, 64'(bus16.result), 64'(exp_res));
    chk({tag, "_flags"}, 64'(bus16.outFlags), 64'(exp_flags));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    take();
  endtask

  initial begin
    int lat;
    int late;
    bus16.in_valid = 1'b0; bus16.op = '0; bus16.input1 = '0; bus16.input2 = '0;
    bus16.out_ready = 1'b0; bus16.flags_wr = 1'b0; bus16.flags_in = '0;
    bus32.in_valid = 1'b0; bus32.op = '0; bus32.input1 = '0; bus32.input2 = '0;
    bus32.out_ready = 1'b0; bus32.flags_wr = 1'b0; bus32.flags_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 64'(bus16.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus16.out_valid), 64'd0);
    chk("rst_result", 64'(bus16.result), 64'd0);
    chk("rst_flags", 64'(bus16.outFlags), 64'd0);

    // Abort a MUL with reset at cycle 5 after accept
    wr_flags(5'b11111);
    @(negedge clk);
    bus16.in_valid = 1'b1; bus16.op = MUL; bus16.input1 = 16'd300; bus16.input2 = 16'd200;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_out_valid", 64'(bus16.out_valid), 64'd0);
    chk("abort_flags", 64'(bus16.outFlags), 64'd0);
    chk("abort_in_ready", 64'(bus16.in_ready), 64'd1);
    late = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (bus16.out_valid) late++;
    end
    chk("abort_no_late", 64'(late), 64'd0);

    wr_flags(5'b00100);
    run_op("addu_wrap",  ADDU,  16'hFFFF, 16'h0001, 16'h0000, 5'b01101, 1);
    run_op("addc",       ADDC,  16'd4,    16'd17,   16'd22,   5'b00000, 1);
    run_op("sub_neg",    SUB,   16'd4,    16'd17,   16'hFFF3, 5'b10001, 1);
    run_op("cmp_eq",     CMP,   16'd17,   16'd17,   16'd17,   5'b01001, 1);
    run_op("cmp_gt",     CMP,   16'd17,   16'd4,    16'd17,   5'b00011, 1);
    run_op("cmp_sneg",   CMP,   16'h8000, 16'h0001, 16'h8000, 5'b10001, 1);
    run_op("cmpu_gt",    CMPU,  16'h8000, 16'h0001, 16'h8000, 5'b00011, 1);
    run_op("lshn3",      LSHN,  16'h0045, 16'd3,    16'h0228, 5'b00011, 4);
    run_op("arshn15",    ARSHN, 16'h8000, 16'd15,   16'hFFFF, 5'b10011, 16);
    run_op("lshn0",      LSHN,  16'h1234, 16'd0,    16'h1234, 5'b00011, 1);
    run_op("mul",        MUL,   16'd300,  16'd200,  16'hEA60, 5'b10010, 17);
    run_op("mul_ovf",    MUL,   16'h0100, 16'h0100, 16'h0000, 5'b01011, 17);
    run_op("xor",        XOR_,  16'hF0F0, 16'h0FF0, 16'hFF00, 5'b10011, 1);
    run_op("not",        NOT_,  16'hFFFF, 16'h0000, 16'h0000, 5'b01011, 1);
    run_op("arsh",       ARSH,  16'h8001, 16'h0000, 16'hC000, 5'b10011, 1);
    run_op("rsh",        RSH,   16'h8001, 16'h0000, 16'h4000, 5'b00011, 1);
    run_op("lsh",        LSH,   16'h8000, 16'h0000, 16'h0000, 5'b01011, 1);
    run_op("and",        AND_,  16'h0FF0, 16'h00FF, 16'h00F0, 5'b00011, 1);
    run_op("illegal",    5'd20, 16'd5,    16'd9,    16'h0000, 5'b00011, 1);
    run_op("add_ovf",    ADD,   16'h7FFF, 16'h0001, 16'h8000, 5'b10110, 1);

    // Stall the consumer while a new request is offered; it must be ignored
    issue(ADD, 16'd1, 16'd2, lat);
    chk("hold_flags0", 64'(bus16.outFlags), 64'(5'b00010));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus16.in_valid = 1'b1; bus16.op = SUB; bus16.input1 = 16'd100; bus16.input2 = 16'd1;
      @(posedge clk);
      #1;
      chk("hold_result", 64'(bus16.result), 64'd3);
      chk("hold_in_ready", 64'(bus16.in_ready), 64'd0);
      chk("hold_out_valid", 64'(bus16.out_valid), 64'd1);
    end
    bus16.in_valid = 1'b0;
    wr_flags(5'b10101);
    take();
    @(posedge clk);
    #1 chk("no_stray_accept", 64'(bus16.out_valid), 64'd0);

    // 32-bit signed overflow
    @(negedge clk);
    bus32.in_valid = 1'b1; bus32.op = ADD; bus32.input1 = 32'h7FFF_FFFF; bus32.input2 = 32'd1;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    chk("w32_valid", 64'(bus32.out_valid), 64'd1);
    chk("w32_res", 64'(bus32.result), 64'h8000_0000);
    chk("w32_flags", 64'(bus32.outFlags), 64'(5'b10100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
